perm_out: RTL and testbench
===========================

# perm_out

Output streamer for the Keccak permutation block. When the permutation core signals that the final 5x5x64 state sits in a state memory, this block reads lanes through one synchronous-read port and emits them on the pushout/stopout/firstout/dout stream, honouring downstream backpressure. It mirrors the din/pushin/stopin/firstin input-loading side and drives the module's output stream.

## Interface
- OUT_LANES, 25: number of lanes emitted per state, legal range 1..25. Smaller values give rate-truncated output; for example, 4 lanes give SHA3-256.
- DW, 64: lane width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  pulse: state memory holds a finished state. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the final lane is accepted.
- done  out  1  one-cycle pulse in the cycle after the final lane is accepted.
- mrx, mry  out  3 each  state-memory read address (lane x, y), registered.
- mrd  in  DW  read data. Valid in the cycle after the address is presented (1-cycle read latency).
- pushout  out  1  dout is valid.
- stopout  in  1  downstream stall. A transfer occurs on an edge where pushout=1 and stopout=0.
- firstout  out  1  marks lane (0,0), the first lane of a state.
- dout  out  DW  lane data.

## Operation
- Lane order: index i = x + 5*y, x fastest. Emitted lanes are i = 0..OUT_LANES-1, i.e. (0,0),(1,0)..(4,0),(0,1)..
- States:
  - IDLE: waits for start.
  - READ: issues addresses, i.e. issue counter < OUT_LANES.
  - DRAIN: all reads issued; waits for the FIFO and in-flight read to empty.
- Transitions:
  - IDLE→READ on start=1.
  - READ→DRAIN after issuing address OUT_LANES-1.
  - DRAIN→IDLE on acceptance of the final lane, which also raises done.
  - When OUT_LANES=1, READ lasts one cycle.
- Buffering:
  - 3-entry output FIFO; the head entry drives pushout/dout/firstout.
  - One read may be in flight. Read data returning from mrd is always written into the FIFO.
  - A new address is issued only when FIFO count + in-flight < 3. The FIFO therefore never overflows, and a read is never dropped under stopout.
- Counters:
  - Issue counter is 5 bits, 0..OUT_LANES-1; x wraps 4→0 with y+1.
  - Accept counter is 5 bits and counts transfers. The final lane is accept count = OUT_LANES-1.
- firstout is carried with each FIFO entry. It is 1 only for the entry read from (0,0).
- Stream rules:
  - While stopout=1, pushout, dout and firstout hold stable.
  - stopout is ignored when pushout=0.
  - pushout never deasserts without a transfer.
- start while busy=1 is ignored; it is not queued.
- Upstream must not write the state memory while busy=1. The block does not check this.

## Timing
- Reset values:
  - pushout=0, firstout=0, dout=0, busy=0, done=0, mrx=0, mry=0.
  - FIFO empty, counters 0, state IDLE.
- start high in cycle c:
  - busy=1 and mrx/mry=(0,0) in cycle c+1.
  - pushout=1, firstout=1, dout=lane(0,0) in cycle c+2.
- Throughput: with stopout held 0, one lane per cycle.
  - The final lane is presented in cycle c+1+OUT_LANES.
  - done=1 and busy=0 in cycle c+2+OUT_LANES.
- Back-to-back: a start in the same cycle as done is accepted, because the state is IDLE.
- Stall: stopout=1 for N cycles delays every subsequent event by exactly N cycles. No lane is duplicated or lost.
- Reset mid-operation: next cycle all outputs are at reset values, FIFO and in-flight read are discarded, and no done is raised.

## Test plan
- Basic drain: memory lane(x,y) = {56'h0, 8'(x+5y)}, OUT_LANES=25, start pulse, stopout=0.
  - Dout sequence 0..24 on consecutive cycles, firstout only on 0.
  - done at c+27.
- Random backpressure: stopout random, 50% high.
  - Same 25 values in order, each exactly once.
  - dout/firstout stable whenever stopout=1 with pushout=1.
- Truncated output: OUT_LANES=4.
  - Emits lanes 0,1,2,3 only; mrx/mry never beyond (3,0).
  - done at c+6.
- Stall at end: stopout=1 from the cycle the final lane appears, for 5 cycles.
  - done delayed by 5 cycles, to c+32 for 25 lanes.
  - FIFO occupancy never exceeds 3.
- Start handling: start asserted during busy is ignored (single stream of 25 lanes); start asserted in the done cycle gives a second stream with firstout on its first lane.
- Mid-stream reset: rst asserted after lane 10 is accepted.
  - Next cycle pushout=0, busy=0, no done.
  - A new start then streams from lane 0 with firstout=1.

Source files
------------

// File: rtl/perm_out.sv
// perm_out: streams the finished Keccak state out of the state memory,
// lane by lane in x-fastest order, through a 3-entry FIFO that absorbs
// downstream backpressure without ever dropping a returning read.
module perm_out #(
  parameter int OUT_LANES = 25,
  parameter int DW        = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    mrx,
  output logic [2:0]    mry,
  input  logic [DW-1:0] mrd,
  output logic          pushout,
  input  logic          stopout,
  output logic          firstout,
  output logic [DW-1:0] dout
);

  localparam logic [4:0] N_L    = 5'(OUT_LANES);
  localparam logic [4:0] LAST_L = 5'(OUT_LANES - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_n;

  logic [4:0]    icnt;       // lanes issued so far
  logic [4:0]    acnt;       // lanes accepted downstream
  logic          av, av_first; // address on mrx/mry is a live read
  logic          rv, rv_first; // mrd carries live read data this cycle
  logic [DW-1:0] fdat [0:2];
  logic          ffst [0:2];
  logic [1:0]    cnt, hp, wi;
  logic [2:0]    wsum;
  logic          head_ok, xfer, fpop, fwr, last, can_issue, issue;

  // Output head: FIFO head if occupied, else the read data arriving on mrd.
  // The bypass gives first-lane latency of two cycles; a stalled bypassed
  // lane is captured into the FIFO so it stays stable on the next cycle.
  always_comb begin
    head_ok   = (cnt != 2'd0);
    pushout   = head_ok | rv;
    dout      = head_ok ? fdat[hp] : (rv ? mrd : '0);
    firstout  = head_ok ? ffst[hp] : (rv & rv_first);
    xfer      = pushout & ~stopout;
    fpop      = xfer & head_ok;
    fwr       = rv & ~(xfer & ~head_ok);
    last      = xfer && (acnt == LAST_L);
    // Count every lane that could still land in the FIFO: stored entries,
    // data on mrd now, and the address currently presented.
    can_issue = (3'(cnt) + 3'(rv) + 3'(av)) < 3'd3;
    issue     = (state == READ) && (icnt != N_L) && can_issue;
    wsum      = 3'(hp) + 3'(cnt);
    wi        = (wsum >= 3'd3) ? 2'(wsum - 3'd3) : wsum[1:0];
    busy      = (state != IDLE);
  end

  // Next-state logic: lane 0 is issued on the start edge, READ issues the rest.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = READ;
      READ:    if ((icnt == N_L) || (issue && (icnt == LAST_L))) state_n = DRAIN;
      DRAIN:   if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Read issue, read pipeline, accept counting and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      icnt     <= '0;
      acnt     <= '0;
      mrx      <= '0;
      mry      <= '0;
      av       <= 1'b0;
      av_first <= 1'b0;
      rv       <= 1'b0;
      rv_first <= 1'b0;
      cnt      <= '0;
      hp       <= '0;
      done     <= 1'b0;
    end else begin
      rv       <= av;
      rv_first <= av_first;
      done     <= last;
      if (state == IDLE && start) begin
        mrx      <= '0;
        mry      <= '0;
        av       <= 1'b1;
        av_first <= 1'b1;
        icnt     <= 5'd1;
      end else if (issue) begin
        if (mrx == 3'd4) begin
          mrx <= '0;
          mry <= mry + 3'd1;
        end else begin
          mrx <= mrx + 3'd1;
        end
        av       <= 1'b1;
        av_first <= 1'b0;
        icnt     <= icnt + 5'd1;
      end else begin
        av       <= 1'b0;
        av_first <= 1'b0;
      end
      if (last)      acnt <= '0;
      else if (xfer) acnt <= acnt + 5'd1;
      if (fpop) hp <= (hp == 2'd2) ? 2'd0 : hp + 2'd1;
      cnt <= cnt + 2'(fwr) - 2'(fpop);
    end
  end

  // FIFO storage; contents are only visible through the count, so no reset.
  always_ff @(posedge clk) begin
    if (fwr) begin
      fdat[wi] <= mrd;
      ffst[wi] <= rv_first;
    end
  end

endmodule

// File: tb/tb_perm_out.sv
// Bench for perm_out: a 25-lane instance checked by a scoreboard monitor
// and a 4-lane instance checked cycle by cycle.
module tb_perm_out;
  localparam int DW = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 1'b0, stopout = 1'b0;
  logic          busy, done, pushout, firstout;
  logic [2:0]    mrx, mry;
  logic [DW-1:0] mrd, dout;

  logic          start4 = 1'b0, stopout4 = 1'b0;
  logic          busy4, done4, pushout4, firstout4;
  logic [2:0]    mrx4, mry4;
  logic [DW-1:0] mrd4, dout4;

  perm_out #(.OUT_LANES(25), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mrx(mrx), .mry(mry), .mrd(mrd), .pushout(pushout), .stopout(stopout),
    .firstout(firstout), .dout(dout));

  perm_out #(.OUT_LANES(4), .DW(DW)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .mrx(mrx4), .mry(mry4), .mrd(mrd4), .pushout(pushout4), .stopout(stopout4),
    .firstout(firstout4), .dout(dout4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] lane(input int idx);
    return {56'h0, 8'(idx)};
  endfunction

  // State memories: synchronous read, one cycle latency.
  always @(posedge clk) begin
    mrd  <= lane(int'(mrx)  + 5 * int'(mry));
    mrd4 <= lane(int'(mrx4) + 5 * int'(mry4));
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [64:0]   exp_q[$];
  int            xfers = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0, max4 = 0;
  logic          hold = 1'b0, hold_f = 1'b0;
  logic [63:0]   hold_d = '0;

  task automatic push_stream();
    for (int i = 0; i < 25; i++) exp_q.push_back({(i == 0), lane(i)});
  endtask

  // Stream monitor: scoreboard compare on every transfer, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        chk("stall_pushout", 64'(pushout), 64'd1);
        chk("stall_dout", dout, hold_d);
        chk("stall_firstout", 64'(firstout), 64'(hold_f));
      end
      hold   <= pushout & stopout;
      hold_d <= dout;
      hold_f <= firstout;
      if (pushout && !stopout) begin
        xfers    <= xfers + 1;
        last_cyc <= cyc;
        chk("lane_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk("dout", dout, e[63:0]);
          chk("firstout", 64'(firstout), 64'(e[64]));
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (int'(mrx4) + 5 * int'(mry4) > max4) max4 <= int'(mrx4) + 5 * int'(mry4);
    end
  end

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 600 && done_cnt < target; i++) @(posedge clk);
    #1;
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  initial begin
    int c, d0, x0;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pushout", 64'(pushout), 64'd0);
    chk("rst_firstout", 64'(firstout), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mrx", 64'(mrx), 64'd0);
    chk("rst_mry", 64'(mry), 64'd0);
    chk("rst_pushout4", 64'(pushout4), 64'd0);
    rst = 1'b0;

    // Basic drain, no backpressure
    d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; c = cyc; push_stream();
    @(posedge clk); #1; start = 1'b0;
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_mrx", 64'(mrx), 64'd0);
    chk("c1_mry", 64'(mry), 64'd0);
    @(posedge clk); #1;
    chk("c2_pushout", 64'(pushout), 64'd1);
    chk("c2_firstout", 64'(firstout), 64'd1);
    chk("c2_dout", dout, 64'd0);
    wait_done(d0 + 1, "basic_done_seen");
    chk("basic_done_cyc", 64'(done_cyc), 64'(c + 27));
    chk("basic_last_cyc", 64'(last_cyc), 64'(c + 26));
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Random backpressure
    d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; push_stream();
    for (int i = 0; i < 600 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stopout = 1'($urandom_range(0, 1));
    end
    stopout = 1'b0;
    chk("rand_done_seen", 64'(done_cnt), 64'(d0 + 1));
    chk("rand_q_empty", 64'(exp_q.size()), 64'd0);

    // Stall on the final lane for 5 cycles
    d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; c = cyc; push_stream();
    @(posedge clk); #1; start = 1'b0;
    repeat (25) @(posedge clk);
    #1; stopout = 1'b1;
    repeat (5) @(posedge clk);
    #1; stopout = 1'b0;
    wait_done(d0 + 1, "stall_done_seen");
    chk("stall_done_cyc", 64'(done_cyc), 64'(c + 32));
    chk("stall_q_empty", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored; start in the done cycle is accepted
    d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; c = cyc; push_stream();
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("b2b_done_pulse", 64'(done), 64'd1);
    start = 1'b1; push_stream();
    @(posedge clk); #1; start = 1'b0;
    wait_done(d0 + 2, "b2b_done_seen");
    chk("b2b_done_cyc", 64'(done_cyc), 64'(c + 54));
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_done_count", 64'(done_cnt), 64'(d0 + 2));
    chk("b2b_q_empty", 64'(exp_q.size()), 64'd0);

    // Mid-stream reset after lane 10 is accepted
    x0 = xfers;
    @(posedge clk); #1; start = 1'b1; push_stream();
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 100 && (xfers - x0) < 11; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_lanes_before_rst", 64'(xfers - x0), 64'd11);
    rst = 1'b1; stopout = 1'b1;
    @(posedge clk); #1;
    chk("mid_pushout", 64'(pushout), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_firstout", 64'(firstout), 64'd0);
    exp_q.delete();
    rst = 1'b0; stopout = 1'b0;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_done", 64'(done_cnt), 64'(d0));
    chk("mid_idle_pushout", 64'(pushout), 64'd0);
    @(posedge clk); #1; start = 1'b1; c = cyc; push_stream();
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("mid_restart_first", 64'(firstout), 64'd1);
    wait_done(d0 + 1, "mid_restart_done_seen");
    chk("mid_restart_done_cyc", 64'(done_cyc), 64'(c + 27));
    chk("mid_restart_q_empty", 64'(exp_q.size()), 64'd0);

    // Truncated output, 4 lanes
    @(posedge clk); #1; start4 = 1'b1; c = cyc;
    @(posedge clk); #1; start4 = 1'b0;
    chk("t4_busy", 64'(busy4), 64'd1);
    chk("t4_mrx", 64'(mrx4), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t4_pushout", 64'(pushout4), 64'd1);
      chk("t4_dout", dout4, lane(i));
      chk("t4_firstout", 64'(firstout4), 64'(i == 0));
    end
    @(posedge clk); #1;
    chk("t4_done_cyc", 64'(cyc), 64'(c + 6));
    chk("t4_done", 64'(done4), 64'd1);
    chk("t4_busy_end", 64'(busy4), 64'd0);
    chk("t4_pushout_end", 64'(pushout4), 64'd0);
    chk("t4_max_addr", 64'(max4), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
